nibble_serializer: RTL and testbench

- Transmit end of the 4-bit nibble bus that feeds the TOP-level `in[3:0]` port of the gate-level test netlists.
- Accepts DATA_W-bit words on a valid/ready slave port and emits them as a sequence of 4-bit nibbles on a valid/ready master port, with first/last framing.
- Used by the simulation harness and the generated stimulus top to drive primitive-cell netlists one nibble per accepted beat.

---
 rtl/nibble_serializer.sv | 122 ++++++++++++
 tb/tb_nibble_serializer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serializer.sv
// Word-to-nibble serializer: accepts DATA_W-bit words on a valid/ready slave port
// and emits them as framed 4-bit nibbles on a valid/ready master port.
module nibble_serializer #(
    parameter int DATA_W    = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [3:0]        m_nibble,
    output logic              m_first,
    output logic              m_last,
    output logic              busy
);

    localparam int NIB   = DATA_W / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    generate
        if ((DATA_W < 4) || ((DATA_W % 4) != 0)) begin : g_bad_width
            $error("nibble_serializer: DATA_W must be a multiple of 4 and at least 4");
        end
    endgenerate

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;

    logic [3:0] nib_arr [NIB];
    logic [3:0] cur_nib;
    logic       at_last;
    logic       accept;
    logic       advance;

    // nib_arr is indexed in transmit order, so idx_reg picks the nibble directly.
    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
            if (MSB_FIRST) begin : g_msb
                assign nib_arr[gi] = data_reg[DATA_W-1-4*gi -: 4];
            end else begin : g_lsb
                assign nib_arr[gi] = data_reg[4*gi +: 4];
            end
        end
        if (NIB == 1) begin : g_single
            assign cur_nib = nib_arr[0];
        end else begin : g_multi
            assign cur_nib = nib_arr[idx_reg];
        end
    endgenerate

    assign at_last = (idx_reg == LAST_IDX);
    assign accept  = s_valid && s_ready;
    assign advance = m_valid && m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                    data_next  = s_data;
                    idx_next   = '0;
                end
            end
            SHIFT: begin
                if (advance) begin
                    if (at_last) begin
                        // A word accepted on the final handshake follows with no bubble.
                        idx_next = '0;
                        if (accept) begin
                            data_next = s_data;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_comb begin
        m_valid  = (state_reg == SHIFT);
        busy     = (state_reg == SHIFT);
        m_nibble = m_valid ? cur_nib : 4'h0;
        m_first  = m_valid && (idx_reg == '0);
        m_last   = m_valid && at_last;
        // rst_n gates s_ready so it reads low for the whole reset pulse.
        s_ready  = rst_n && ((state_reg == IDLE) ||
                             ((state_reg == SHIFT) && at_last && m_ready));
    end

endmodule

// File: tb/tb_nibble_serializer.sv
// Self-checking bench for nibble_serializer: MSB-first and LSB-first 16-bit
// instances share stimulus, plus a 4-bit instance for the single-nibble case.
module tb_nibble_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        s_valid;
    logic [15:0] s_data;
    logic        m_ready;

    logic        a_s_ready, a_m_valid, a_m_first, a_m_last, a_busy;
    logic [3:0]  a_m_nibble;
    logic        b_s_ready, b_m_valid, b_m_first, b_m_last, b_busy;
    logic [3:0]  b_m_nibble;

    logic        c_s_valid, c_m_ready;
    logic [3:0]  c_s_data;
    logic        c_s_ready, c_m_valid, c_m_first, c_m_last, c_busy;
    logic [3:0]  c_m_nibble;

    nibble_serializer #(.DATA_W(16), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(a_s_ready), .s_data(s_data),
        .m_valid(a_m_valid), .m_ready(m_ready), .m_nibble(a_m_nibble),
        .m_first(a_m_first), .m_last(a_m_last), .busy(a_busy));

    nibble_serializer #(.DATA_W(16), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(b_s_ready), .s_data(s_data),
        .m_valid(b_m_valid), .m_ready(m_ready), .m_nibble(b_m_nibble),
        .m_first(b_m_first), .m_last(b_m_last), .busy(b_busy));

    nibble_serializer #(.DATA_W(4), .MSB_FIRST(1'b1)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .s_valid(c_s_valid), .s_ready(c_s_ready), .s_data(c_s_data),
        .m_valid(c_m_valid), .m_ready(c_m_ready), .m_nibble(c_m_nibble),
        .m_first(c_m_first), .m_last(c_m_last), .busy(c_busy));

    int tests    = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] word;
        logic [15:0] exp_msb;   // emitted nibbles as hex digits, first one leftmost
        logic [15:0] exp_lsb;
    } vec_t;

    typedef struct {
        logic [3:0] nib;
        logic       first;
        logic       last;
    } nib_t;

    nib_t qa[$];
    nib_t qb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] digit(input logic [15:0] seq, input int k);
        digit = 4'((seq >> (12 - 4 * k)) & 16'hF);
    endfunction

    // Entered and left at posedge+1; m_ready held high throughout.
    task automatic send_single(input logic [15:0] w, input logic [15:0] em, input logic [15:0] el);
        logic [6:0] ea, eb;
        s_valid = 1'b1;
        s_data  = w;
        m_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("%h accept ready", w), {a_s_ready, b_s_ready}, 2'b11);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_data  = 16'($urandom);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ea = {1'b1, (k == 0), (k == 3), digit(em, k)};
            eb = {1'b1, (k == 0), (k == 3), digit(el, k)};
            chk($sformatf("%h msb nib%0d", w, k), {a_m_valid, a_m_first, a_m_last, a_m_nibble}, ea);
            chk($sformatf("%h lsb nib%0d", w, k), {b_m_valid, b_m_first, b_m_last, b_m_nibble}, eb);
            chk($sformatf("%h s_ready nib%0d", w, k), a_s_ready, (k == 3));
        end
        @(negedge clk);
        chk($sformatf("%h idle msb", w), {a_m_valid, a_busy, a_s_ready}, 3'b001);
        chk($sformatf("%h idle lsb", w), {b_m_valid, b_busy, b_s_ready}, 3'b001);
        @(posedge clk); #1;
        $display("[TB] single word %h sent", w);
    endtask

    task automatic push_word(input logic [15:0] w);
        nib_t n;
        for (int i = 0; i < 4; i++) begin
            n.first = (i == 0);
            n.last  = (i == 3);
            n.nib   = 4'((w >> (12 - 4 * i)) & 16'hF);
            qa.push_back(n);
            n.nib   = 4'((w >> (4 * i)) & 16'hF);
            qb.push_back(n);
        end
    endtask

    initial begin
        vec_t       vecs[6];
        logic [3:0] w4[3];
        logic [15:0] sd;
        logic       held;
        logic       exp_ready;

        vecs[0] = '{16'hA5C3, 16'hA5C3, 16'h3C5A};
        vecs[1] = '{16'h1234, 16'h1234, 16'h4321};
        vecs[2] = '{16'h0000, 16'h0000, 16'h0000};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
        vecs[4] = '{16'h8001, 16'h8001, 16'h1008};
        vecs[5] = '{16'h0F0F, 16'h0F0F, 16'hF0F0};
        w4[0] = 4'h7; w4[1] = 4'h8; w4[2] = 4'h9;

        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        c_s_valid = 1'b0; c_s_data = '0; c_m_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset msb", {a_s_ready, a_m_valid, a_m_nibble, a_m_first, a_m_last, a_busy}, 9'h0);
        chk("reset lsb", {b_s_ready, b_m_valid, b_m_nibble, b_m_first, b_m_last, b_busy}, 9'h0);
        chk("reset w4",  {c_s_ready, c_m_valid, c_m_nibble, c_m_first, c_m_last, c_busy}, 9'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset ready", {a_s_ready, b_s_ready, c_s_ready, a_m_valid}, 4'b1110);
        @(posedge clk); #1;

        // Table-driven single words
        for (int v = 0; v < 6; v++) begin
            send_single(vecs[v].word, vecs[v].exp_msb, vecs[v].exp_lsb);
        end

        // Backpressure: m_ready low for 3 cycles while nibble 2 of 0x1234 is presented
        s_valid = 1'b1; s_data = 16'h1234; m_ready = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("bp nib1", {a_m_valid, a_m_first, a_m_last, a_m_nibble}, {3'b110, 4'h1});
        @(posedge clk); #1;
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("bp hold%0d", i), {a_m_valid, a_m_first, a_m_last, a_m_nibble}, {3'b100, 4'h2});
            chk($sformatf("bp s_ready%0d", i), a_s_ready, 1'b0);
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        @(negedge clk);
        chk("bp nib2 release", {a_m_valid, a_m_first, a_m_last, a_m_nibble}, {3'b100, 4'h2});
        @(negedge clk);
        chk("bp nib3", {a_m_valid, a_m_first, a_m_last, a_m_nibble}, {3'b100, 4'h3});
        @(negedge clk);
        chk("bp nib4", {a_m_valid, a_m_first, a_m_last, a_m_nibble}, {3'b101, 4'h4});
        @(negedge clk);
        chk("bp idle", {a_m_valid, a_s_ready}, 2'b01);
        @(posedge clk); #1;
        $display("[TB] backpressure word 1234 sent");

        // Back-to-back 0x1111 then 0x2222 with no bubble
        s_valid = 1'b1; s_data = 16'h1111; m_ready = 1'b1;
        @(posedge clk); #1;
        s_data = 16'h2222;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("b2b nib%0d", k), {a_m_valid, a_m_first, a_m_last, a_m_nibble},
                {1'b1, (k % 4 == 0), (k % 4 == 3), (k < 4) ? 4'h1 : 4'h2});
            chk($sformatf("b2b s_ready%0d", k), a_s_ready, (k % 4 == 3));
            if (k == 3) begin
                @(posedge clk); #1;
                s_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b idle", {a_m_valid, a_busy}, 2'b00);
        @(posedge clk); #1;
        $display("[TB] back-to-back words 1111 2222 sent");

        // Reset mid-word
        s_valid = 1'b1; s_data = 16'hBEEF; m_ready = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("rst nibB", a_m_nibble, 4'hB);
        @(negedge clk);
        chk("rst nibE", a_m_nibble, 4'hE);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async reset msb", {a_m_valid, a_busy, a_s_ready, a_m_nibble}, 7'h0);
        chk("async reset lsb", {b_m_valid, b_busy, b_s_ready}, 3'b000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after reset release", {a_m_valid, a_s_ready}, 2'b01);
        @(posedge clk); #1;
        send_single(16'h0F0F, 16'h0F0F, 16'hF0F0);

        // DATA_W=4: one word per cycle
        c_s_valid = 1'b1; c_s_data = w4[0]; c_m_ready = 1'b1;
        @(negedge clk);
        chk("w4 ready", c_s_ready, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            c_s_valid = (i < 2);
            c_s_data  = (i < 2) ? w4[i+1] : 4'h0;
            @(negedge clk);
            chk($sformatf("w4 word%0d", i), {c_m_valid, c_m_first, c_m_last, c_m_nibble}, {3'b111, w4[i]});
            chk($sformatf("w4 s_ready%0d", i), c_s_ready, 1'b1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("w4 idle", {c_m_valid, c_busy}, 2'b00);
        @(posedge clk); #1;
        $display("[TB] w4 words 7 8 9 sent");

        // Randomized traffic against a nibble-queue model
        held = 1'b0;
        sd   = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!held) begin
                s_valid = ($urandom_range(0, 2) != 0);
                sd      = 16'($urandom);
            end
            s_data  = sd;
            m_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            exp_ready = (qa.size() == 0) || ((qa.size() == 1) && m_ready);
            chk($sformatf("rnd%0d ready", cyc), {a_s_ready, b_s_ready}, {exp_ready, exp_ready});
            chk($sformatf("rnd%0d valid", cyc), {a_m_valid, b_m_valid, a_busy},
                {3{qa.size() != 0}});
            if (qa.size() != 0) begin
                chk($sformatf("rnd%0d msb", cyc), {a_m_first, a_m_last, a_m_nibble},
                    {qa[0].first, qa[0].last, qa[0].nib});
                chk($sformatf("rnd%0d lsb", cyc), {b_m_first, b_m_last, b_m_nibble},
                    {qb[0].first, qb[0].last, qb[0].nib});
            end
            if ((qa.size() != 0) && m_ready) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
            end
            if (s_valid && exp_ready) begin
                push_word(sd);
                held = 1'b0;
                $display("[TB] random word %h accepted at cycle %0d", sd, cyc);
            end else begin
                held = s_valid;
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("rnd drain", {a_m_valid, b_m_valid, a_s_ready}, 3'b001);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
